// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, funct3 encodings, FSM states and special-case constants for muldiv_unit
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int CYCLES = XLEN;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [XLEN-1:0] QUOT_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitude/sign extraction per funct3 and final result negation
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic [2*XLEN-1:0] raw_i,
  input  logic              neg_i,
  output logic [XLEN-1:0]   mag_a_o,
  output logic [XLEN-1:0]   mag_b_o,
  output logic              sa_o,
  output logic              sb_o,
  output logic [2*XLEN-1:0] fixed_o
);
  assign sa_o = a_i[XLEN-1] && (funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
  assign sb_o = b_i[XLEN-1] && (funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
  assign mag_a_o = sa_o ? -a_i : a_i;
  assign mag_b_o = sb_o ? -b_i : b_i;
  assign fixed_o = neg_i ? -raw_i : raw_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 33-cycle latency.
// MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, rd_q, rd_d, rd_out_q, rd_out_d;
  logic [2:0] f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic sa_q, sa_d, sb_q, sb_d, div0_q, div0_d, done_q, done_d, wb_en_q, wb_en_d;
  logic [XLEN-1:0] mag_a, mag_b, diff;
  logic sa, sb, neg, is_div, rem_op, div0, ge;
  logic [2*XLEN-1:0] raw, fixed;
  logic [XLEN:0] sum, sh;

  muldiv_sign_fix u_fix (
    .funct3_i(funct3),
    .a_i     (rs1_data),
    .b_i     (rs2_data),
    .raw_i   (raw),
    .neg_i   (neg),
    .mag_a_o (mag_a),
    .mag_b_o (mag_b),
    .sa_o    (sa),
    .sb_o    (sb),
    .fixed_o (fixed)
  );

  assign is_div = f3_q[2];
  assign rem_op = is_div && f3_q[1];
  assign raw = is_div ? {{XLEN{1'b0}}, rem_op ? hi_q : lo_q} : {hi_q, lo_q};
  assign neg = rem_op ? sa_q : sa_q ^ sb_q;
  assign div0 = funct3[2] && rs2_data == '0;
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign sh = {hi_q, lo_q[XLEN-1]};
  assign ge = sh >= {1'b0, b_q};
  assign diff = sh[XLEN-1:0] - b_q;

`ifdef MULDIV_EARLY_OUT_EN
  logic ovf, early;
  assign ovf = (funct3 == F3_DIV || funct3 == F3_REM) && rs1_data == INT_MIN && rs2_data == '1;
  assign early = div0 || ovf || (!funct3[2] && (rs1_data == '0 || rs2_data == '0));
`endif

  // hi/lo hold {product} for multiply and {remainder, quotient} for divide
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    f3_d = f3_q;
    rd_d = rd_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    sa_d = sa_q;
    sb_d = sb_q;
    div0_d = div0_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d = 1'b0;
    wb_en_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        cnt_d = '0;
        f3_d = funct3;
        rd_d = rd_in;
        a_d = mag_a;
        b_d = mag_b;
        sa_d = sa;
        sb_d = sb;
        div0_d = div0;
        hi_d = '0;
        lo_d = funct3[2] ? mag_a : mag_b;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) begin
          state_d = FIN;
          hi_d = div0 ? mag_a : '0;
          lo_d = ovf ? INT_MIN : '0;
        end
`endif
      end
      CALC: begin
        hi_d = is_div ? (ge ? diff : sh[XLEN-1:0]) : sum[XLEN:1];
        lo_d = is_div ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q + 5'd1;
        state_d = cnt_q == 5'(CYCLES-1) ? FIN : CALC;
      end
      default: begin
        result_d = is_div ? (div0_q && !rem_op ? QUOT_ONES : fixed[XLEN-1:0])
                          : (f3_q == F3_MUL ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN]);
        rd_out_d = rd_q;
        done_d = 1'b1;
        wb_en_d = rd_q != '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      f3_q <= '0;
      rd_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      div0_q <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q <= 1'b0;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      rd_q <= rd_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      div0_q <= div0_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q <= done_d;
      wb_en_q <= wb_en_d;
    end
  end

  assign busy = state_q != IDLE;
  assign done = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;
  assign wb_en = wb_en_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors checked against literals and a per-cycle behavioural model
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0] rd_in = '0;
  logic busy, done, wb_en;
  logic [31:0] result;
  logic [4:0] rd_out;
  int checks = 0, errors = 0, n_done = 0, cyc = 0, k = 0, n = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_wb = 1'b0;
  logic [31:0] m_res = '0, m_out = '0;
  logic [4:0] m_rd = '0, m_rd_out = '0;
  int m_due = 0;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ss, su, uu;
    logic signed [31:0] x, y, q, r;
    logic ovf;
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    su = {{32{a[31]}}, a} * {32'b0, b};
    uu = {32'b0, a} * {32'b0, b};
    ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
    x = a;
    y = b;
    q = 0;
    r = 0;
    if (b != 0 && !ovf) begin
      q = x / y;
      r = x % y;
    end
    case (f)
      3'd0: return ss[31:0];
      3'd1: return ss[63:32];
      3'd2: return su[63:32];
      3'd3: return uu[63:32];
      3'd4: return b == 0 ? 32'hFFFFFFFF : ovf ? 32'h80000000 : q;
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : r;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    m_wb = 1'b0;
    if (!rst) begin
      m_busy = 1'b0;
      m_out = '0;
      m_rd_out = '0;
    end else if (m_busy) begin
      if (cyc == m_due) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_wb = m_rd != 0;
        m_out = m_res;
        m_rd_out = m_rd;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_due = cyc + ref_lat(funct3, rs1_data, rs2_data);
      m_res = ref_op(funct3, rs1_data, rs2_data);
      m_rd = rd_in;
    end
  end

  always @(negedge clk) begin
    if (done) n_done++;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("wb_en", 32'(wb_en), 32'(m_wb));
    chk("result", result, m_out);
    chk("rd_out", 32'(rd_out), 32'(m_rd_out));
  end

  task automatic wait_done();
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                    input logic [31:0] exp, input int lat, input bit b2b, input string nm);
    if (!b2b) @(negedge clk);
    funct3 = f;
    rs1_data = a;
    rs2_data = b;
    rd_in = rd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " result"}, result, exp);
    chk({nm, " rd_out"}, 32'(rd_out), 32'(rd));
    chk({nm, " wb_en"}, 32'(wb_en), 32'(rd != 0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset result", result, 0);
    chk("reset rd_out", 32'(rd_out), 0);
    chk("reset wb_en", 32'(wb_en), 0);
    rst = 1'b1;
    op(3'd0, 32'd7, -32'sd3, 5'd5, 32'hFFFFFFEB, 33, 0, "mul");
    op(3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1, 32'h00000000, 33, 0, "mulh");
    op(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, 33, 0, "mulhsu");
    op(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h7FFFFFFF, 33, 0, "mulhu");
    op(3'd4, -32'sd7, 32'd2, 5'd6, 32'hFFFFFFFD, 33, 0, "div");
    op(3'd6, -32'sd7, 32'd2, 5'd7, 32'hFFFFFFFF, 33, 0, "rem");
    op(3'd5, 32'd100, 32'd0, 5'd8, 32'hFFFFFFFF, SPL, 0, "divu0");
    op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h00000000, SPL, 0, "rem_ovf");
    op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, SPL, 0, "div_ovf");
    op(3'd4, -32'sd5, 32'd0, 5'd11, 32'hFFFFFFFF, SPL, 0, "div0");
    op(3'd6, -32'sd5, 32'd0, 5'd12, 32'hFFFFFFFB, SPL, 0, "rem0");
    op(3'd0, 32'd0, 32'h12345, 5'd13, 32'h0, SPL, 0, "mul_zero");
    op(3'd5, 32'hFFFFFFFF, 32'd3, 5'd14, 32'h55555555, 33, 0, "divu");
    op(3'd7, 32'd100, 32'd7, 5'd15, 32'd2, 33, 0, "remu");
    op(3'd5, 32'd100, 32'd7, 5'd16, 32'd14, 33, 1, "b2b_divu");
    op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 33, 0, "rd0");
    op(3'd4, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, SPL, 0, "div5_0");
    @(negedge clk);
    funct3 = 3'd0;
    rs1_data = 32'd6;
    rs2_data = 32'd7;
    rd_in = 5'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = n_done;
    repeat (9) @(negedge clk);
    funct3 = 3'd3;
    rs1_data = 32'd100;
    rs2_data = 32'd100;
    rd_in = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ignore result", result, 32'd42);
    chk("ignore rd_out", 32'(rd_out), 32'd9);
    repeat (40) @(negedge clk);
    chk("ignore done count", 32'(n_done - k), 32'd1);
    @(negedge clk);
    funct3 = 3'd4;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_in = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = n_done;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort result", result, 0);
    chk("abort rd_out", 32'(rd_out), 0);
    repeat (40) @(negedge clk);
    chk("abort no done", 32'(n_done - k), 0);
    op(3'd4, 32'd1000, 32'd3, 5'd4, 32'd333, 33, 0, "after_abort");
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
